// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch squash and the interrupt-entry sequence.
// Optional flags save during interrupt entry is enabled by defining INT_FLAGS_SAVE_EN.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idexMemRead,
  input  logic [3:0]  idexRegDest,
  input  logic [3:0]  ifidSrc1,
  input  logic [3:0]  ifidSrc2,
  input  logic        ifidUsesSrc2,
  input  logic        ifidValid,
  input  logic [15:0] ifidPC,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  input  logic        intReq,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic        intPushPC,
  output logic        intPushFlags,
  output logic        intVector,
  output logic        intAck,
  output logic [15:0] retPC
);

`ifdef INT_FLAGS_SAVE_EN
  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_DRAIN      = 3'd1,
    S_PUSH_PC    = 3'd2,
    S_PUSH_FLAGS = 3'd3,
    S_VECTOR     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_DRAIN      = 3'd1,
    S_PUSH_PC    = 3'd2,
    S_VECTOR     = 3'd4
  } state_t;
`endif

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  state_t      r_state;
  logic        r_pending;
  logic [1:0]  r_cnt;
  logic [15:0] r_ret_pc;

  logic w_load_use;
  logic w_accept;

  assign w_load_use = idexMemRead &&
                      ((idexRegDest == ifidSrc1) || (ifidUsesSrc2 && (idexRegDest == ifidSrc2)));
  assign w_accept   = (r_state == S_RUN) && r_pending && ifidValid && !branchTaken && !w_load_use;
  assign retPC      = r_ret_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_pending <= 1'b0;
      r_cnt     <= 2'd0;
      r_ret_pc  <= 16'h0000;
    end else begin
      // A new pulse in the acceptance cycle must survive the clear so it is serviced later.
      r_pending <= intReq | (r_pending & ~w_accept);
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_ret_pc <= ifidPC;
            r_cnt    <= DRAIN_LOAD;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (branchTaken) begin
            r_ret_pc <= branchTarget;
          end
          if (r_cnt == 2'd0) begin
            r_state <= S_PUSH_PC;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
`ifdef INT_FLAGS_SAVE_EN
        S_PUSH_PC:    r_state <= S_PUSH_FLAGS;
        S_PUSH_FLAGS: r_state <= S_VECTOR;
`else
        S_PUSH_PC:    r_state <= S_VECTOR;
`endif
        S_VECTOR:     r_state <= S_RUN;
        default:      r_state <= S_RUN;
      endcase
    end
  end

  always_comb begin
    pcWrite      = 1'b0;
    ifidWrite    = 1'b0;
    ifidFlush    = 1'b0;
    idexBubble   = 1'b0;
    intPushPC    = 1'b0;
    intPushFlags = 1'b0;
    intVector    = 1'b0;
    intAck       = 1'b0;
    if (rst) begin
      // Present the quiescent RUN controls while reset is held, whatever state we were in.
      pcWrite   = 1'b1;
      ifidWrite = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          pcWrite   = 1'b1;
          ifidWrite = 1'b1;
          if (branchTaken) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
          end else if (w_load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
          end else if (w_accept) begin
            pcWrite    = 1'b0;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
          end
        end
        S_DRAIN: begin
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
        end
        S_PUSH_PC: begin
          intPushPC  = 1'b1;
          idexBubble = 1'b1;
        end
`ifdef INT_FLAGS_SAVE_EN
        S_PUSH_FLAGS: begin
          intPushFlags = 1'b1;
          idexBubble   = 1'b1;
        end
`endif
        S_VECTOR: begin
          pcWrite   = 1'b1;
          intVector = 1'b1;
          ifidFlush = 1'b1;
          intAck    = 1'b1;
        end
        default: begin
          pcWrite   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage 16-bit RISC core. It generates write-enable, flush and bubble controls for the PC, IF/ID and ID/EX buffers, so the EX/MEM buffer receives correct bubble flags downstream. It detects load-use hazards and squashes wrong-path instructions on taken branches. It also runs the interrupt-entry sequence: drain the pipe, push the return PC, push the flags, then redirect to the vector.

## Interface
Parameters:
- DRAIN_CYCLES, 2, cycles spent draining EX/MEM after interrupt acceptance (1..3)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- idexMemRead  in  1  instruction in ID/EX is a load/POP
- idexRegDest  in  4  destination register of the ID/EX instruction
- ifidSrc1  in  4  source 1 register of the IF/ID instruction
- ifidSrc2  in  4  source 2 register of the IF/ID instruction
- ifidUsesSrc2  in  1  IF/ID instruction reads src2
- ifidValid  in  1  IF/ID holds a real instruction, not a bubble
- ifidPC  in  16  PC of the IF/ID instruction
- branchTaken  in  1  EX resolved a taken branch/jump this cycle
- branchTarget  in  16  target of that branch
- intReq  in  1  one-cycle interrupt request pulse
- pcWrite  out  1  PC register load enable
- ifidWrite  out  1  IF/ID load enable
- ifidFlush  out  1  IF/ID loads a bubble
- idexBubble  out  1  ID/EX loads a bubble and asserts its bubble flag
- intPushPC  out  1  EX injects PUSH of retPC
- intPushFlags  out  1  EX injects PUSH of CCR
- intVector  out  1  PC selects the interrupt vector
- intAck  out  1  one-cycle acknowledge
- retPC  out  16  latched return address

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- States: RUN, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR. All outputs are decoded from state plus current inputs in RUN, and from state only elsewhere.
- Default outputs:
  - RUN: pcWrite=1, ifidWrite=1.
  - Other states: pcWrite=0, ifidWrite=0.
  - All other outputs are 0 unless stated.
- RUN, priority order:
  1. branchTaken: ifidFlush=1, idexBubble=1, pcWrite=1. Load-use is suppressed because the dependent instruction is squashed.
  2. Load-use: condition is idexMemRead && (idexRegDest==ifidSrc1 || (ifidUsesSrc2 && idexRegDest==ifidSrc2)). Response: pcWrite=0, ifidWrite=0, idexBubble=1.
  3. Interrupt acceptance: pending && ifidValid && no branch && no load-use. Response: retPC<=ifidPC, ifidFlush=1, idexBubble=1, pcWrite=0, pending cleared, go to DRAIN with counter=DRAIN_CYCLES-1.
- pending flag: set by any intReq pulse in any state, cleared only on acceptance. A second pulse while pending is already set is merged into it.
- DRAIN: ifidFlush=1, idexBubble=1.
  - branchTaken here (the older instruction in EX redirects) overwrites retPC<=branchTarget.
  - Counter decrements each cycle; at 0 go to PUSH_PC.
- PUSH_PC: intPushPC=1, idexBubble=1 for one cycle, then go to PUSH_FLAGS. See Configuration.
- PUSH_FLAGS: intPushFlags=1, idexBubble=1 for one cycle, then go to VECTOR.
- VECTOR: pcWrite=1, intVector=1, ifidFlush=1, intAck=1 for one cycle, then go to RUN.
- branchTaken in PUSH_PC, PUSH_FLAGS or VECTOR is ignored; the pipe is empty by construction.

## Timing
- Reset values: state=RUN, pending=0, counter=0, retPC=0.
  - Outputs during and directly after reset: pcWrite=1, ifidWrite=1, all others 0.
- Reset mid-sequence returns to RUN the next edge. The pending request is dropped.
- Load-use stall lasts exactly one cycle per hazard. The ID/EX bubble clears the hazard condition the following cycle.
- Interrupt latency from acceptance edge to vector fetch is 1+DRAIN_CYCLES+2+1 cycles; that is 6 at default with flags save.
- intReq arriving in the acceptance cycle, or in any non-RUN state, is serviced on the first eligible RUN cycle after returning.
- retPC is stable from the acceptance edge until the next acceptance, except for a DRAIN branch overwrite.

## Configuration
- INT_FLAGS_SAVE_EN defined: the full sequence above runs.
- Not defined:
  - PUSH_FLAGS state does not exist; PUSH_PC goes directly to VECTOR.
  - intPushFlags is tied 0.
  - Latency is reduced by one cycle.

## Test plan
- Load-use: idexMemRead=1, idexRegDest=3, ifidSrc1=3 -> one cycle of pcWrite=0, ifidWrite=0, idexBubble=1, then normal flow. Same with ifidSrc2=3 but ifidUsesSrc2=0 -> no stall.
- Branch beats hazard: load-use condition plus branchTaken=1 simultaneously -> ifidFlush=1, idexBubble=1, pcWrite=1, no stall.
- Interrupt: intReq pulse, ifidValid=1, ifidPC=0x0040 -> retPC=0x0040. Subsequent cycles in order: DRAIN ×2, intPushPC, intPushFlags, then intVector=1 with intAck=1 on cycle 6 after acceptance.
- Branch in DRAIN: branchTaken=1, branchTarget=0x0100 during the first DRAIN cycle -> retPC=0x0100 at intPushPC.
- Deferred request: intReq during PUSH_PC -> second sequence accepted on the first RUN cycle with ifidValid=1 after VECTOR.
- Reset in PUSH_FLAGS -> next cycle in RUN, pcWrite=1, intAck never asserted, pending=0. With INT_FLAGS_SAVE_EN undefined, the interrupt scenario shows intVector on cycle 5 and intPushFlags never set.
